// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
//   state_e        : arbiter sequencer states
//   REGION_*       : addr[31:28] values of the four slave regions
//   CE_*           : one-hot chip-enable codes, bit order {eram, uart, sram, urom}
//   SLV_*          : bit index of each slave inside the chip-enable vector
//   bus_payload_t  : request payload latched into the bus registers
package bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HB_W   = 2;
    localparam int unsigned CE_W   = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [REG_W-1:0] REGION_UROM = 4'h0;
    localparam logic [REG_W-1:0] REGION_SRAM = 4'h1;
    localparam logic [REG_W-1:0] REGION_UART = 4'h2;
    localparam logic [REG_W-1:0] REGION_ERAM = 4'h3;

    localparam logic [CE_W-1:0] CE_NONE = 4'b0000;
    localparam logic [CE_W-1:0] CE_UROM = 4'b0001;
    localparam logic [CE_W-1:0] CE_SRAM = 4'b0010;
    localparam logic [CE_W-1:0] CE_UART = 4'b0100;
    localparam logic [CE_W-1:0] CE_ERAM = 4'b1000;

    localparam logic [1:0] SLV_UROM = 2'd0;
    localparam logic [1:0] SLV_SRAM = 2'd1;
    localparam logic [1:0] SLV_UART = 2'd2;
    localparam logic [1:0] SLV_ERAM = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [HB_W-1:0]   hb;
    } bus_payload_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the slaves.
//   m0_* / m1_*        : master request payload in, completion/rdata/err out
//   bus_*_o            : registered request towards the slaves
//   bus_gnt_i, *_data_i: slave grant (ORed) and per-slave read data
// Modport master is the arbiter's view; modport slave is the environment's view.
interface bus_arbiter_if;
    import bus_pkg::*;

    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic              m0_we_i;
    logic [HB_W-1:0]   m0_hb_i;
    logic              m0_gnt_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_err_o;

    logic              m1_req_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic              m1_we_i;
    logic [HB_W-1:0]   m1_hb_i;
    logic              m1_gnt_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_err_o;

    logic              bus_req_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_we_o;
    logic [HB_W-1:0]   bus_hb_o;
    logic [CE_W-1:0]   bus_ce_o;
    logic              bus_gnt_i;

    logic [DATA_W-1:0] urom_data_i;
    logic [DATA_W-1:0] sram_data_i;
    logic [DATA_W-1:0] uart_data_i;
    logic [DATA_W-1:0] eram_data_i;

    modport master (
        input  m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i, m0_hb_i,
        output m0_gnt_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_hb_i,
        output m1_gnt_o, m1_rdata_o, m1_err_o,
        output bus_req_o, bus_addr_o, bus_wdata_o, bus_we_o, bus_hb_o, bus_ce_o,
        input  bus_gnt_i,
        input  urom_data_i, sram_data_i, uart_data_i, eram_data_i
    );

    modport slave (
        output m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i, m0_hb_i,
        input  m0_gnt_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_hb_i,
        input  m1_gnt_o, m1_rdata_o, m1_err_o,
        input  bus_req_o, bus_addr_o, bus_wdata_o, bus_we_o, bus_hb_o, bus_ce_o,
        output bus_gnt_i,
        output urom_data_i, sram_data_i, uart_data_i, eram_data_i
    );

endinterface

// File: rtl/bus_addr_decoder.sv
// Peripheral address decoder: top address nibble to one-hot chip enable.
//   region_i : addr[31:28]
//   ce_c_o   : one-hot {eram, uart, sram, urom}, zero on a miss (combinational)
//   hit_c_o  : region maps to a slave (combinational)
module bus_addr_decoder
    import bus_pkg::*;
(
    input  logic [REG_W-1:0] region_i,
    output logic [CE_W-1:0]  ce_c_o,
    output logic             hit_c_o
);

    always_comb begin
        ce_c_o  = CE_NONE;
        hit_c_o = 1'b1;
        case (region_i)
            REGION_UROM: ce_c_o = CE_UROM;
            REGION_SRAM: ce_c_o = CE_SRAM;
            REGION_UART: ce_c_o = CE_UART;
            REGION_ERAM: ce_c_o = CE_ERAM;
            default:     hit_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the peripheral bus.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bif           : master requests/completions, registered bus request,
//                   slave grant and slave read data (see bus_arbiter_if)
// TIMEOUT_CYCLES bounds the ACTIVE cycles spent waiting for a slave grant.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    bus_arbiter_if.master bif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic              prio_q, prio_d;     // 1: m1 favoured on a tie
    logic              win_q, win_d;       // index of the master being served
    logic              miss_q, miss_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    bus_payload_t      pay_q, pay_d;
    logic              bus_req_q, bus_req_d;
    logic [CE_W-1:0]   ce_q, ce_d;
    logic              m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic              sel_m1;
    bus_payload_t      sel_pay;
    logic [CE_W-1:0]   dec_ce;
    logic              dec_hit;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] slv_rdata;
    logic              resp_fire;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    // Winner select: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        if (bif.m0_req_i && bif.m1_req_i) begin
            sel_m1 = prio_q;
        end else begin
            sel_m1 = bif.m1_req_i;
        end
        if (sel_m1) begin
            sel_pay.addr  = bif.m1_addr_i;
            sel_pay.wdata = bif.m1_wdata_i;
            sel_pay.we    = bif.m1_we_i;
            sel_pay.hb    = bif.m1_hb_i;
        end else begin
            sel_pay.addr  = bif.m0_addr_i;
            sel_pay.wdata = bif.m0_wdata_i;
            sel_pay.we    = bif.m0_we_i;
            sel_pay.hb    = bif.m0_hb_i;
        end
    end

    bus_addr_decoder u_dec (
        .region_i (sel_pay.addr[ADDR_W-1 -: REG_W]),
        .ce_c_o   (dec_ce),
        .hit_c_o  (dec_hit)
    );

    // Read data of the slave currently enabled.
    always_comb begin
        slv_rdata = '0;
        if (ce_q[SLV_UROM]) begin
            slv_rdata = bif.urom_data_i;
        end else if (ce_q[SLV_SRAM]) begin
            slv_rdata = bif.sram_data_i;
        end else if (ce_q[SLV_UART]) begin
            slv_rdata = bif.uart_data_i;
        end else if (ce_q[SLV_ERAM]) begin
            slv_rdata = bif.eram_data_i;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Sequencer next state. A decode miss spends one ACTIVE cycle with the bus
    // idle so its error response arrives with the same latency as a hit.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        win_d      = win_q;
        miss_d     = miss_q;
        cnt_d      = cnt_q;
        pay_d      = pay_q;
        bus_req_d  = bus_req_q;
        ce_d       = ce_q;
        resp_fire  = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (bif.m0_req_i || bif.m1_req_i) begin
                    win_d     = sel_m1;
                    pay_d     = sel_pay;
                    miss_d    = ~dec_hit;
                    bus_req_d = dec_hit;
                    ce_d      = dec_ce;
                    cnt_d     = '0;
                    state_d   = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                cnt_d = cnt_inc;
                if (miss_q) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end else if (bif.bus_gnt_i) begin
                    resp_fire  = 1'b1;
                    resp_rdata = slv_rdata;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end
                if (resp_fire) begin
                    bus_req_d = 1'b0;
                    ce_d      = CE_NONE;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                prio_d  = ~win_q;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                ce_d      = CE_NONE;
                state_d   = ST_IDLE;
            end
        endcase

        m0_gnt_d   = resp_fire && !win_q;
        m0_err_d   = resp_fire && !win_q && resp_err;
        m0_rdata_d = (resp_fire && !win_q) ? resp_rdata : '0;
        m1_gnt_d   = resp_fire && win_q;
        m1_err_d   = resp_fire && win_q && resp_err;
        m1_rdata_d = (resp_fire && win_q) ? resp_rdata : '0;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            win_q      <= 1'b0;
            miss_q     <= 1'b0;
            cnt_q      <= '0;
            pay_q      <= '0;
            bus_req_q  <= 1'b0;
            ce_q       <= CE_NONE;
            m0_gnt_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_gnt_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            win_q      <= win_d;
            miss_q     <= miss_d;
            cnt_q      <= cnt_d;
            pay_q      <= pay_d;
            bus_req_q  <= bus_req_d;
            ce_q       <= ce_d;
            m0_gnt_q   <= m0_gnt_d;
            m0_err_q   <= m0_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_gnt_q   <= m1_gnt_d;
            m1_err_q   <= m1_err_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign bif.bus_req_o   = bus_req_q;
    assign bif.bus_ce_o    = ce_q;
    assign bif.bus_addr_o  = pay_q.addr;
    assign bif.bus_wdata_o = pay_q.wdata;
    assign bif.bus_we_o    = pay_q.we;
    assign bif.bus_hb_o    = pay_q.hb;
    assign bif.m0_gnt_o    = m0_gnt_q;
    assign bif.m0_err_o    = m0_err_q;
    assign bif.m0_rdata_o  = m0_rdata_q;
    assign bif.m1_gnt_o    = m1_gnt_q;
    assign bif.m1_err_o    = m1_err_q;
    assign bif.m1_rdata_o  = m1_rdata_q;

endmodule
